regfile_dump_reader: RTL and testbench

Sequential read-side companion to the register file write-enable decoder. On a `start` pulse it walks register file addresses through a read port, captures each value and streams (index, data) pairs out over a valid/ready handshake. Used by the debug/trace path to dump architectural register state without stalling the write path.

---
 rtl/regfile_dump_reader_if.sv | 27 ++
 rtl/regfile_dump_reader.sv | 95 +++++++++
 tb/tb_regfile_dump_reader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// Handshake and read-port bundle between the register dump reader and its
// environment (register file read port plus pair sink).
interface regfile_dump_reader_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_idx;
  logic [DW-1:0] out_data;

  modport master (
    input  start, abort, rd_data, out_ready,
    output busy, done, rd_addr, out_valid, out_idx, out_data
  );

  modport slave (
    output start, abort, rd_data, out_ready,
    input  busy, done, rd_addr, out_valid, out_idx, out_data
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks register file addresses through a read port and streams captured
// (index, data) pairs over a valid/ready handshake, one pair every two cycles.
module regfile_dump_reader #(
  parameter int NREGS     = 32,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int SKIP_ZERO = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_dump_reader_if.master  bus
);
  localparam logic [AW-1:0] START_ADDR = (SKIP_ZERO != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NREGS - 1);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  state_t        state_reg;
  logic [AW-1:0] idx_reg;
  logic [AW-1:0] out_idx_reg;
  logic [DW-1:0] out_data_reg;
  logic          out_valid_reg;
  logic          done_reg;
  logic          busy_reg;

  // Outputs are registered alongside the state so they are pure Moore decodes
  // with no path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= START_ADDR;
      out_idx_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (bus.abort) begin
      state_reg     <= IDLE;
      idx_reg       <= START_ADDR;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          idx_reg <= START_ADDR;
          if (bus.start) begin
            state_reg <= READ;
            busy_reg  <= 1'b1;
          end
        end
        READ: begin
          // The captured value is frozen here; later writes do not reach it.
          out_data_reg  <= bus.rd_data;
          out_idx_reg   <= idx_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            if (idx_reg == LAST_ADDR) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              idx_reg   <= idx_reg + AW'(1);
              state_reg <= READ;
            end
          end
        end
        DONE: begin
          // A start seen here is dropped; it must be re-asserted in IDLE.
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          idx_reg   <= START_ADDR;
          state_reg <= IDLE;
        end
        default: begin
          state_reg     <= IDLE;
          idx_reg       <= START_ADDR;
          out_valid_reg <= 1'b0;
          done_reg      <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_addr   = idx_reg;
  assign bus.out_idx   = out_idx_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.done      = done_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a cycle table for the first pairs,
// then hand sequences for full dumps, backpressure, abort, writes and reset.
module tb_regfile_dump_reader;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_dump_reader_if #(.AW(AW), .DW(DW)) b1 ();
  regfile_dump_reader_if #(.AW(AW), .DW(DW)) b0 ();

  logic [DW-1:0] regs [NREGS];
  always_comb b1.rd_data = regs[b1.rd_addr];
  always_comb b0.rd_data = regs[b0.rd_addr];

  regfile_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW), .SKIP_ZERO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.master));
  regfile_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW), .SKIP_ZERO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.master));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        start;
    logic        abort;
    logic        ready;
    logic        busy;
    logic        valid;
    logic        done;
    logic [4:0]  addr;
    logic [4:0]  oidx;
    logic [31:0] odata;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pair1(input int idx, input string name);
    int t = 0;
    while (!(b1.out_valid && b1.out_idx == idx) && t < 200) begin
      step();
      t++;
    end
    chk(name, (b1.out_valid && b1.out_idx == idx), 1);
  endtask

  task automatic wait_done1(input string name);
    int t = 0;
    b1.out_ready = 1'b1;
    while (!b1.done && t < 200) begin
      step();
      t++;
    end
    chk(name, b1.done, 1);
    step();
  endtask

  task automatic run_basic();
    int k = 1;
    int busy_c = 0;
    int done_c = 0;
    int done_at = 0;
    b1.out_ready = 1'b1;
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (b1.busy) busy_c++;
      if (b1.done) begin
        done_c++;
        done_at = n;
      end
      if (b1.out_valid) begin
        $display("basic pair idx=%0d data=0x%08h", b1.out_idx, b1.out_data);
        chk("basic_idx", b1.out_idx, k);
        chk("basic_data", b1.out_data, 32'h1000_0000 + k);
        k++;
      end
      if (done_at != 0 && !b1.busy) break;
      step();
    end
    chk("basic_pairs", k - 1, 31);
    chk("basic_busy_cycles", busy_c, 63);
    chk("basic_done_cycle", done_at, 63);
    chk("basic_done_count", done_c, 1);
    chk("basic_busy_after", b1.busy, 0);
  endtask

  task automatic run_backpressure();
    b1.out_ready = 1'b1;
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    wait_pair1(7, "bp_reach_idx7");
    b1.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      $display("bp stall cycle %0d valid=%0d idx=%0d data=0x%08h", c, b1.out_valid, b1.out_idx, b1.out_data);
      chk("bp_valid", b1.out_valid, 1);
      chk("bp_idx", b1.out_idx, 7);
      chk("bp_data", b1.out_data, 32'h1000_0007);
    end
    b1.out_ready = 1'b1;
    step();
    chk("bp_gap_valid", b1.out_valid, 0);
    step();
    chk("bp_next_valid", b1.out_valid, 1);
    chk("bp_next_idx", b1.out_idx, 8);
    chk("bp_next_data", b1.out_data, 32'h1000_0008);
    wait_done1("bp_done");
  endtask

  task automatic run_abort();
    int bad = 0;
    b1.out_ready = 1'b1;
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    wait_pair1(12, "abort_reach_idx12");
    b1.abort = 1'b1;
    step();
    b1.abort = 1'b0;
    $display("abort next cycle valid=%0d busy=%0d done=%0d", b1.out_valid, b1.busy, b1.done);
    chk("abort_valid", b1.out_valid, 0);
    chk("abort_busy", b1.busy, 0);
    chk("abort_addr", b1.rd_addr, 1);
    for (int c = 0; c < 3; c++) begin
      if (b1.done || b1.busy) bad++;
      step();
    end
    chk("abort_no_done", bad, 0);
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    step();
    chk("abort_restart_idx", b1.out_idx, 1);
    chk("abort_restart_data", b1.out_data, 32'h1000_0001);
    wait_done1("abort_restart_done");
  endtask

  task automatic run_write();
    b1.out_ready = 1'b1;
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    wait_pair1(5, "wr_reach_idx5");
    b1.out_ready = 1'b0;
    regs[5] = 32'hDEAD_BEEF;
    step();
    $display("write during dump idx=%0d data=0x%08h", b1.out_idx, b1.out_data);
    chk("wr_old_data", b1.out_data, 32'h1000_0005);
    wait_done1("wr_done1");
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    wait_pair1(5, "wr_reach_idx5_again");
    $display("redump idx=%0d data=0x%08h", b1.out_idx, b1.out_data);
    chk("wr_new_data", b1.out_data, 32'hDEAD_BEEF);
    wait_done1("wr_done2");
    regs[5] = 32'h1000_0005;
  endtask

  task automatic run_skip0();
    int k = 0;
    int done_c = 0;
    int done_at = 0;
    logic mid_sent = 1'b0;
    b0.out_ready = 1'b1;
    b0.start = 1'b1;
    step();
    for (int n = 1; n <= 120; n++) begin
      b0.start = 1'b0;
      if (b0.done) begin
        done_c++;
        done_at = n;
        b0.start = 1'b1;
      end
      if (b0.out_valid) begin
        $display("skip0 pair idx=%0d data=0x%08h", b0.out_idx, b0.out_data);
        chk("skip0_idx", b0.out_idx, k);
        chk("skip0_data", b0.out_data, (k == 0) ? 32'h0 : 32'h1000_0000 + k);
        if (k == 10 && !mid_sent) begin
          b0.start = 1'b1;
          mid_sent = 1'b1;
        end
        k++;
      end
      if (done_at != 0 && !b0.busy) break;
      step();
    end
    b0.start = 1'b0;
    chk("skip0_pairs", k, 32);
    chk("skip0_done_count", done_c, 1);
    chk("skip0_done_cycle", done_at, 65);
    chk("skip0_busy_after_done_start", b0.busy, 0);
    step();
    chk("skip0_still_idle", b0.busy, 0);
  endtask

  task automatic run_async_reset();
    int bad = 0;
    b1.out_ready = 1'b1;
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    wait_pair1(3, "rst_reach_idx3");
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-hold valid=%0d busy=%0d", b1.out_valid, b1.busy);
    chk("rst_valid", b1.out_valid, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_done", b1.done, 0);
    chk("rst_addr", b1.rd_addr, 1);
    chk("rst_oidx", b1.out_idx, 0);
    chk("rst_odata", b1.out_data, 0);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (b1.busy || b1.out_valid || b1.done || b1.out_idx != 0 || b1.out_data != 0) bad++;
    end
    chk("rst_hold_idle", bad, 0);
  endtask

  initial begin
    for (int k = 0; k < NREGS; k++) regs[k] = (k == 0) ? 32'h0 : 32'h1000_0000 + k;
    b1.start = 1'b0; b1.abort = 1'b0; b1.out_ready = 1'b0;
    b0.start = 1'b0; b0.abort = 1'b0; b0.out_ready = 1'b0;

    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 32'h1000_0001};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 32'h1000_0001};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 5'd1, 32'h1000_0001};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd2, 32'h1000_0002};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd2, 32'h1000_0002};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 32'h1000_0003};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd3, 32'h1000_0003};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd3, 32'h1000_0003};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd3, 32'h1000_0003};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd3, 32'h1000_0003};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd3, 32'h1000_0003};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", b1.busy, 0);
    chk("reset_valid", b1.out_valid, 0);
    chk("reset_done", b1.done, 0);
    chk("reset_addr1", b1.rd_addr, 1);
    chk("reset_addr0", b0.rd_addr, 0);
    chk("reset_oidx", b1.out_idx, 0);
    chk("reset_odata", b1.out_data, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      b1.start = vt[i].start;
      b1.abort = vt[i].abort;
      b1.out_ready = vt[i].ready;
      step();
      $display("vec %0d busy=%0d valid=%0d done=%0d addr=%0d idx=%0d data=0x%08h",
               i, b1.busy, b1.out_valid, b1.done, b1.rd_addr, b1.out_idx, b1.out_data);
      chk("vec_busy", b1.busy, vt[i].busy);
      chk("vec_valid", b1.out_valid, vt[i].valid);
      chk("vec_done", b1.done, vt[i].done);
      chk("vec_addr", b1.rd_addr, vt[i].addr);
      chk("vec_oidx", b1.out_idx, vt[i].oidx);
      chk("vec_odata", b1.out_data, vt[i].odata);
    end
    b1.start = 1'b0;
    b1.abort = 1'b0;
    b1.out_ready = 1'b0;
    step();

    run_basic();
    step();
    run_backpressure();
    run_abort();
    run_write();
    run_skip0();
    run_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
